// File: rtl/fpmult_pkg.sv
// Shared types, constants and result classification for the FP32 multiplier front end.
package fpmult_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] man;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] EXP_MAX  = 8'hFF;
  localparam int         EXP_BIAS = 127;

  // Returns {nan, inf, zero}; denormals set none of them.
  function automatic logic [2:0] class_fp32(input fp32_t v);
    logic is_nan, is_inf, is_zero;
    is_zero = (v.exp == 8'd0) && (v.man == 23'd0);
    is_inf  = (v.exp == EXP_MAX) && (v.man == 23'd0);
    is_nan  = (v.exp == EXP_MAX) && (v.man != 23'd0);
    return {is_nan, is_inf, is_zero};
  endfunction

endpackage

// File: rtl/fpmult_arbiter_multiplierunit.sv
// Combinational IEEE-754 binary32 multiplier, round-to-nearest-even.
// Subnormal inputs are treated as zero and underflowing results flush to signed zero.
module multiplierunit
  import fpmult_pkg::*;
(
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic [31:0] dataR
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  fp32_t             fa, fb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign;
  logic [47:0]       prod;
  logic [22:0]       mant;
  logic [23:0]       mant_r;
  logic              guard, sticky, rnd;
  logic signed [10:0] exp_s;

  assign fa     = dataA;
  assign fb     = dataB;
  assign a_nan  = (fa.exp == EXP_MAX) && (fa.man != 23'd0);
  assign b_nan  = (fb.exp == EXP_MAX) && (fb.man != 23'd0);
  assign a_inf  = (fa.exp == EXP_MAX) && (fa.man == 23'd0);
  assign b_inf  = (fb.exp == EXP_MAX) && (fb.man == 23'd0);
  assign a_zero = (fa.exp == 8'd0);
  assign b_zero = (fb.exp == 8'd0);
  assign sign   = fa.sign ^ fb.sign;
  assign prod   = 48'({1'b1, fa.man}) * 48'({1'b1, fb.man});

  always_comb begin
    exp_s = $signed({3'b000, fa.exp}) + $signed({3'b000, fb.exp}) - 11'(EXP_BIAS);
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_s  = exp_s + 11'sd1;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    rnd    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {23'd0, rnd};
    // Rounding carry-out leaves the fraction at zero, only the exponent moves.
    if (mant_r[23]) exp_s = exp_s + 11'sd1;

    dataR = {sign, exp_s[7:0], mant_r[22:0]};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      dataR = QNAN;
    end else if (a_inf || b_inf) begin
      dataR = {sign, EXP_MAX, 23'd0};
    end else if (a_zero || b_zero) begin
      dataR = {sign, 31'd0};
    end else if (exp_s >= 11'sd255) begin
      dataR = {sign, EXP_MAX, 23'd0};
    end else if (exp_s <= 11'sd0) begin
      dataR = {sign, 31'd0};
    end
  end

endmodule

// File: rtl/fpmult_arbiter.sv
// Round-robin front end sharing one combinational FP32 multiplier between two requesters.
// state | meaning: IDLE = granting, BUSY = LAT compute cycles, RESP = holding result for owner.
module fpmult_arbiter
  import fpmult_pkg::*;
#(
  parameter int LAT  = 1,
  parameter int NREQ = 2
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][31:0] req_a,
  input  logic [NREQ-1:0][31:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [2:0]            rsp_flags,
  output logic                  busy
);

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t          state_q;
  logic            ptr_q, owner_q, gnt, any_valid;
  logic [3:0]      cnt_q;
  logic [31:0]     a_q, b_q, mul_r;
  logic [31:0]     rsp_data_q;
  logic [2:0]      rsp_flags_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic            busy_q;

  multiplierunit u_mult (
    .dataA(a_q),
    .dataB(b_q),
    .dataR(mul_r)
  );

  assign any_valid = |req_valid;
  assign gnt       = req_valid[ptr_q] ? ptr_q : ~ptr_q;

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && any_valid) req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= 4'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      rsp_data_q  <= 32'd0;
      rsp_flags_q <= 3'd0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            a_q     <= req_a[gnt];
            b_q     <= req_b[gnt];
            owner_q <= gnt;
            ptr_q   <= ~gnt;
            cnt_q   <= CNT_LOAD;
            state_q <= BUSY;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            rsp_data_q           <= mul_r;
            rsp_flags_q          <= class_fp32(mul_r);
            rsp_valid_q          <= '0;
            rsp_valid_q[owner_q] <= 1'b1;
            state_q              <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready[owner_q]) begin
            rsp_valid_q <= '0;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fpmult_arbiter.sv
// Directed bench: LAT=1 instance for function/fairness/backpressure, LAT=4 instance for mid-flight reset.
module tb_fpmult_arbiter;

  logic             clk = 1'b0;
  logic             nreset, nreset4;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][31:0] req_a, req_b;
  logic [31:0]      rsp_data;
  logic [2:0]       rsp_flags;
  logic             busy;
  logic [1:0]       req_valid4, req_ready4, rsp_valid4, rsp_ready4;
  logic [1:0][31:0] req_a4, req_b4;
  logic [31:0]      rsp_data4;
  logic [2:0]       rsp_flags4;
  logic             busy4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpmult_arbiter #(.LAT(1), .NREQ(2)) dut (
    .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy)
  );

  fpmult_arbiter #(.LAT(4), .NREQ(2)) dut4 (
    .clk(clk), .nreset(nreset4), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_a(req_a4), .req_b(req_b4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
    .rsp_data(rsp_data4), .rsp_flags(rsp_flags4), .busy(busy4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request on the LAT=1 instance and returns what came back plus the
  // number of edges between the accept edge and rsp_valid showing up.
  task automatic transact(input int idx, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] d, output logic [2:0] f, output int lat);
    int w;
    req_a[idx] = a;
    req_b[idx] = b;
    req_valid = 2'b00;
    req_valid[idx] = 1'b1;
    rsp_ready = 2'b11;
    #1;
    w = 0;
    while (!req_ready[idx] && w < 10) begin
      tick();
      w++;
    end
    tick();
    req_valid = 2'b00;
    lat = 0;
    while (!rsp_valid[idx] && lat < 20) begin
      tick();
      lat++;
    end
    d = rsp_data;
    f = rsp_flags;
    tick();
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a = '0;
    req_b = '0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 00000000", rsp_data); end
    checks++; if (rsp_flags !== 3'b000) begin errors++; $display("FAIL reset_rsp_flags: got %b expected 000", rsp_flags); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    nreset = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    req_a[0] = 32'h3FC00000; req_b[0] = 32'hC0000000;
    req_a[1] = 32'h3F800000; req_b[1] = 32'h00000000;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL fair_grant0: got %b expected 01", req_ready); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fair_busy: got %b expected 1", busy); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL fair_ready_busy: got %b expected 00", req_ready); end
    tick();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL fair_rsp_valid0: got %b expected 01", rsp_valid); end
    checks++; if (rsp_data !== 32'hC0400000) begin errors++; $display("FAIL fair_data0: got %h expected c0400000", rsp_data); end
    checks++; if (rsp_flags !== 3'b000) begin errors++; $display("FAIL fair_flags0: got %b expected 000", rsp_flags); end
    tick();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL fair_grant1: got %b expected 10", req_ready); end
    tick();
    tick();
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL fair_rsp_valid1: got %b expected 10", rsp_valid); end
    checks++; if (rsp_data !== 32'h00000000) begin errors++; $display("FAIL fair_data1: got %h expected 00000000", rsp_data); end
    checks++; if (rsp_flags !== 3'b001) begin errors++; $display("FAIL fair_flags1: got %b expected 001", rsp_flags); end
    tick();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL fair_grant2: got %b expected 01", req_ready); end
    req_valid = 2'b00;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fair_idle_no_req: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [2:0]  f;
    int          lat;
    transact(0, 32'h40000000, 32'h40400000, d, f, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_latency: got %0d expected 1", lat); end
    checks++; if (d !== 32'h40C00000) begin errors++; $display("FAIL basic_2x3: got %h expected 40c00000", d); end
    checks++; if (f !== 3'b000) begin errors++; $display("FAIL basic_flags: got %b expected 000", f); end
    transact(1, 32'h3FC00000, 32'hC0000000, d, f, lat);
    checks++; if (d !== 32'hC0400000) begin errors++; $display("FAIL basic_req1_only: got %h expected c0400000", d); end
    transact(0, 32'h40400000, 32'h40400000, d, f, lat);
    checks++; if (d !== 32'h41100000) begin errors++; $display("FAIL basic_3x3: got %h expected 41100000", d); end
  endtask

  task automatic test_special();
    logic [31:0] d;
    logic [2:0]  f;
    int          lat;
    transact(0, 32'h7F800000, 32'h40000000, d, f, lat);
    checks++; if (d !== 32'h7F800000) begin errors++; $display("FAIL inf_data: got %h expected 7f800000", d); end
    checks++; if (f !== 3'b010) begin errors++; $display("FAIL inf_flags: got %b expected 010", f); end
    transact(1, 32'h7F800000, 32'h00000000, d, f, lat);
    checks++; if (f !== 3'b100) begin errors++; $display("FAIL nan_flags: got %b expected 100", f); end
    checks++; if (d[30:23] !== 8'hFF) begin errors++; $display("FAIL nan_exp: got %h expected ff", d[30:23]); end
    checks++; if ((d[22:0] != 23'd0) !== 1'b1) begin errors++; $display("FAIL nan_man: got %h expected nonzero", d[22:0]); end
  endtask

  task automatic test_backpressure();
    req_a[0] = 32'h40000000; req_b[0] = 32'h40400000;
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    #1;
    tick();
    req_valid = 2'b11;
    rsp_ready = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL bp_rsp_valid[%0d]: got %b expected 01", i, rsp_valid); end
      checks++; if (rsp_data !== 32'h40C00000) begin errors++; $display("FAIL bp_rsp_data[%0d]: got %h expected 40c00000", i, rsp_data); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 00", i, req_ready); end
      tick();
    end
    rsp_ready = 2'b01;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_drop: got %b expected 0", busy); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL bp_rsp_valid_drop: got %b expected 00", rsp_valid); end
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_grant: got %b expected 10", req_ready); end
    req_valid = 2'b00;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_after: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midflight();
    int   lat;
    logic [1:0] seen;
    req_a4[1] = 32'h40000000; req_b4[1] = 32'h40400000;
    req_valid4 = 2'b10;
    rsp_ready4 = 2'b11;
    #1;
    tick();
    req_valid4 = 2'b00;
    lat = 0;
    while (!rsp_valid4[1] && lat < 20) begin
      tick();
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL lat4_latency: got %0d expected 4", lat); end
    checks++; if (rsp_data4 !== 32'h40C00000) begin errors++; $display("FAIL lat4_data: got %h expected 40c00000", rsp_data4); end
    tick();
    req_a4[0] = 32'h7F800000; req_b4[0] = 32'h40000000;
    req_valid4 = 2'b01;
    #1;
    tick();
    req_valid4 = 2'b00;
    tick();
    tick();
    checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy4); end
    nreset4 = 1'b0;
    #1;
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy4); end
    checks++; if (rsp_valid4 !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 00", rsp_valid4); end
    checks++; if (rsp_data4 !== 32'h0) begin errors++; $display("FAIL rst_rsp_data: got %h expected 00000000", rsp_data4); end
    checks++; if (rsp_flags4 !== 3'b000) begin errors++; $display("FAIL rst_rsp_flags: got %b expected 000", rsp_flags4); end
    checks++; if (req_ready4 !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b expected 00", req_ready4); end
    tick();
    nreset4 = 1'b1;
    tick();
    seen = 2'b00;
    for (int i = 0; i < 8; i++) begin
      seen = seen | rsp_valid4;
      tick();
    end
    checks++; if (seen !== 2'b00) begin errors++; $display("FAIL rst_no_response: got %b expected 00", seen); end
    req_a4[0] = 32'h40400000; req_b4[0] = 32'h40400000;
    req_a4[1] = 32'h3F800000; req_b4[1] = 32'h3F800000;
    req_valid4 = 2'b11;
    #1;
    checks++; if (req_ready4 !== 2'b01) begin errors++; $display("FAIL rst_ptr_zero: got %b expected 01", req_ready4); end
    tick();
    req_valid4 = 2'b00;
    lat = 0;
    while (!rsp_valid4[0] && lat < 20) begin
      tick();
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL post_rst_latency: got %0d expected 4", lat); end
    checks++; if (rsp_data4 !== 32'h41100000) begin errors++; $display("FAIL post_rst_data: got %h expected 41100000", rsp_data4); end
    tick();
  endtask

  initial begin
    nreset4 = 1'b0;
    req_valid4 = 2'b00;
    rsp_ready4 = 2'b00;
    req_a4 = '0;
    req_b4 = '0;
    test_reset();
    nreset4 = 1'b1;
    tick();
    test_fairness();
    test_basic();
    test_special();
    test_backpressure();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
